// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: op codes, FSM states
// and small op-decoding helpers.
package dm_lsu_pkg;

    localparam int DMOP_WIDTH = 4;

    typedef enum logic [DMOP_WIDTH-1:0] {
        DMOP_LB   = 4'd0,
        DMOP_LH   = 4'd1,
        DMOP_LHA  = 4'd2,
        DMOP_LHBR = 4'd3,
        DMOP_LW   = 4'd4,
        DMOP_LWA  = 4'd5,
        DMOP_LWBR = 4'd6,
        DMOP_LD   = 4'd7,
        DMOP_SB   = 4'd8,
        DMOP_SH   = 4'd9,
        DMOP_SHBR = 4'd10,
        DMOP_SW   = 4'd11,
        DMOP_SWBR = 4'd12,
        DMOP_SD   = 4'd13
    } dm_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } dm_state_e;

    function automatic logic op_is_store(input logic [DMOP_WIDTH-1:0] op);
        return op inside {DMOP_SB, DMOP_SH, DMOP_SHBR, DMOP_SW, DMOP_SWBR, DMOP_SD};
    endfunction

    // 0 = byte, 1 = half, 2 = word, 3 = double.
    function automatic logic [1:0] op_size_log2(input logic [DMOP_WIDTH-1:0] op);
        case (op)
            DMOP_LB, DMOP_SB:                                      return 2'd0;
            DMOP_LH, DMOP_LHA, DMOP_LHBR, DMOP_SH, DMOP_SHBR:      return 2'd1;
            DMOP_LW, DMOP_LWA, DMOP_LWBR, DMOP_SW, DMOP_SWBR:      return 2'd2;
            default:                                               return 2'd3;
        endcase
    endfunction

    // Unused encodings, and the 64-bit-only ops on a 32-bit array, are errors.
    function automatic logic op_is_legal(input logic [DMOP_WIDTH-1:0] op, input int data_w);
        case (op)
            DMOP_LWA, DMOP_LD, DMOP_SD: return data_w == 64;
            4'd14, 4'd15:               return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_steer.sv
// Combinational big-endian byte-lane steering: store placement and byte enables,
// load extraction with optional byte-reverse and sign extension, misalign detect.
module dm_lane_steer
    import dm_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NBYTES = DATA_W / 8,
    localparam int OFF_W  = $clog2(NBYTES)
) (
    input  logic [DMOP_WIDTH-1:0] op_i,
    input  logic [OFF_W-1:0]      off_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic [DATA_W-1:0]     ld_word_i,
    output logic [DATA_W-1:0]     st_lane_o,
    output logic [NBYTES-1:0]     st_be_o,
    output logic [DATA_W-1:0]     ld_data_o,
    output logic                  misalign_o
);

    int                nbytes;
    int                off_al;
    int                shamt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] st_val;
    logic [DATA_W-1:0] ld_raw;
    logic              brev_op;
    logic              signed_op;

    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] v, input int n);
        byte_rev = '0;
        for (int i = 0; i < NBYTES; i++)
            if (i < n) byte_rev[8*i +: 8] = v[8*(n-1-i) +: 8];
    endfunction

    always_comb begin
        // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
        mask      = '0;
        st_be_o   = '0;
        nbytes    = 1 << op_size_log2(op_i);
        if (nbytes > NBYTES) nbytes = NBYTES;
        misalign_o = (int'(off_i) & (nbytes - 1)) != 0;
        // Aligned offset keeps the shift non-negative; misaligned results are discarded upstream.
        off_al    = int'(off_i) & ~(nbytes - 1);
        shamt     = 8 * (NBYTES - off_al - nbytes);
        brev_op   = op_i inside {DMOP_LHBR, DMOP_LWBR, DMOP_SHBR, DMOP_SWBR};
        signed_op = op_i inside {DMOP_LHA, DMOP_LWA};

        for (int i = 0; i < NBYTES; i++)
            if (i < nbytes) mask[8*i +: 8] = 8'hFF;

        st_val    = brev_op ? byte_rev(st_data_i, nbytes) : (st_data_i & mask);
        st_lane_o = st_val << shamt;
        for (int k = 0; k < NBYTES; k++)
            st_be_o[k] = (k >= off_al) && (k < off_al + nbytes);

        ld_raw = (ld_word_i >> shamt) & mask;
        if (brev_op) ld_raw = byte_rev(ld_raw, nbytes);
        ld_data_o = ld_raw;
        if (signed_op && ld_raw[8*nbytes-1]) ld_data_o = ld_raw | ~mask;
    end

endmodule

// File: rtl/dm_lsu.sv
// MEM-stage load/store unit: data array plus a valid/ready request/response FSM
// with range/alignment checks and 1- or 2-cycle array read latency.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DMOP_WIDTH-1:0] req_op_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam bit LAT2   = (RD_LAT == 2);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    dm_state_e             state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic [DMOP_WIDTH-1:0] op_q;
    logic [OFF_W-1:0]      off_lo_q;
    logic [DATA_W-1:0]     rd_word_q;

    logic [ADDR_W-1:0]     off;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  out_of_range;
    logic                  req_err;
    logic                  is_store;
    logic                  accept;
    logic                  wr_en;
    logic                  ld_phase;
    logic [DMOP_WIDTH-1:0] steer_op;
    logic [OFF_W-1:0]      steer_off;
    logic [DATA_W-1:0]     ld_word;
    logic [DATA_W-1:0]     st_lane;
    logic [NBYTES-1:0]     st_be;
    logic [DATA_W-1:0]     ld_data;
    logic                  misalign;

    assign off          = req_addr_i - BASE_ADDR;
    assign word_idx     = off[OFF_W +: DEPTH_LOG2];
    assign out_of_range = (off >> (OFF_W + DEPTH_LOG2)) != '0;
    assign is_store     = op_is_store(req_op_i);
    assign req_err      = out_of_range || misalign || !op_is_legal(req_op_i, DATA_W);
    assign accept       = req_valid_i && req_ready_q;
    // Gating with rst_n drops a store that coincides with reset assertion.
    assign wr_en        = accept && is_store && !req_err && rst_n;

    // With two-cycle latency the steering unit extracts from the latched word in RD_WAIT.
    assign ld_phase  = LAT2 && (state_q == ST_RD_WAIT);
    assign steer_op  = ld_phase ? op_q : req_op_i;
    assign steer_off = ld_phase ? off_lo_q : off[OFF_W-1:0];
    assign ld_word   = LAT2 ? rd_word_q : mem_q[word_idx];

    dm_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .op_i       (steer_op),
        .off_i      (steer_off),
        .st_data_i  (req_wdata_i),
        .ld_word_i  (ld_word),
        .st_lane_o  (st_lane),
        .st_be_o    (st_be),
        .ld_data_o  (ld_data),
        .misalign_o (misalign)
    );

    // NOTE: the data array carries no reset; only control and response state are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NBYTES; k++)
                if (st_be[k]) mem_q[word_idx][DATA_W-1-8*k -: 8] <= st_lane[DATA_W-1-8*k -: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            op_q        <= '0;
            off_lo_q    <= '0;
            rd_word_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        op_q        <= req_op_i;
                        off_lo_q    <= off[OFF_W-1:0];
                        rd_word_q   <= mem_q[word_idx];
                        if (LAT2 && !is_store && !req_err) begin
                            state_q <= ST_RD_WAIT;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                            rsp_rdata_q <= (is_store || req_err) ? '0 : ld_data;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= ld_data;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: a 32-bit/1-cycle instance and a 64-bit/2-cycle instance checked
// against a byte-array reference model with directed and random traffic.
module tb_dm_lsu;
    import dm_lsu_pkg::*;

    localparam logic [31:0] A_BASE = 32'h0;
    localparam logic [31:0] B_BASE = 32'h100;

    logic        clk;
    logic        rst_n;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [3:0]  a_req_op;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [3:0]  b_req_op;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_rsp_rdata;

    bit [7:0] mem_a [256];
    bit [7:0] mem_b [256];

    int n_cmp;
    int n_bad;

    dm_lsu #(.DATA_W(32), .DEPTH_LOG2(6), .ADDR_W(32), .BASE_ADDR(A_BASE), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_op_i(a_req_op),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
    );

    dm_lsu #(.DATA_W(64), .DEPTH_LOG2(5), .ADDR_W(32), .BASE_ADDR(B_BASE), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic vld(input bit sel);
        return sel ? b_rsp_valid : a_rsp_valid;
    endfunction
    function automatic logic errf(input bit sel);
        return sel ? b_rsp_err : a_rsp_err;
    endfunction
    function automatic logic [63:0] rdat(input bit sel);
        return sel ? b_rsp_rdata : {32'h0, a_rsp_rdata};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [31:0] addr, input logic [63:0] wdata);
        if (sel) begin
            b_req_valid = v; b_req_op = op; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = v; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata[31:0];
        end
    endtask

    task automatic set_rr(input bit sel, input logic v);
        if (sel) b_rsp_ready = v;
        else     a_rsp_ready = v;
    endtask

    function automatic bit is_st(input logic [3:0] op);
        return op inside {DMOP_SB, DMOP_SH, DMOP_SHBR, DMOP_SW, DMOP_SWBR, DMOP_SD};
    endfunction

    // Reference: memory is a flat byte array; values are big-endian byte strings.
    function automatic void model(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                                  input logic [63:0] wdata, output logic [63:0] data,
                                  output logic err);
        int          n;
        bit          sx, br, legal;
        logic [31:0] off;
        logic [63:0] v;
        logic [7:0]  bt;
        off = addr - (sel ? B_BASE : A_BASE);
        legal = 1'b1; sx = 1'b0; br = 1'b0; n = 1;
        case (op)
            DMOP_LB, DMOP_SB:     n = 1;
            DMOP_LH, DMOP_SH:     n = 2;
            DMOP_LHA:             begin n = 2; sx = 1'b1; end
            DMOP_LHBR, DMOP_SHBR: begin n = 2; br = 1'b1; end
            DMOP_LW, DMOP_SW:     n = 4;
            DMOP_LWA:             begin n = 4; sx = 1'b1; legal = sel; end
            DMOP_LWBR, DMOP_SWBR: begin n = 4; br = 1'b1; end
            DMOP_LD, DMOP_SD:     begin n = 8; legal = sel; end
            default:              legal = 1'b0;
        endcase
        err  = !legal || (off % n) != 0 || off >= 256;
        data = '0;
        if (err) return;
        if (is_st(op)) begin
            for (int j = 0; j < n; j++) begin
                bt = br ? wdata[8*j +: 8] : wdata[8*(n-1-j) +: 8];
                if (sel) mem_b[int'(off) + j] = bt;
                else     mem_a[int'(off) + j] = bt;
            end
            return;
        end
        v = '0;
        for (int j = 0; j < n; j++) begin
            bt = sel ? mem_b[int'(off) + j] : mem_a[int'(off) + j];
            if (br) v = v | (64'(bt) << (8 * j));
            else    v = (v << 8) | 64'(bt);
        end
        if (sx && v[8*n-1]) v = v | (~64'h0 << (8 * n));
        if (!sel) v[63:32] = '0;
        data = v;
    endfunction

    // One full transaction: accept, latency, response contents, hold stability, release.
    task automatic do_req(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                          input logic [63:0] wdata, input int hold,
                          input bit has_want, input logic [63:0] want);
        logic [63:0] exp_d;
        logic        exp_e;
        int          exp_lat, lat, waited;
        string       nm;
        nm = $sformatf("%s/op%0d@%h", sel ? "B" : "A", op, addr);
        model(sel, op, addr, wdata, exp_d, exp_e);
        exp_lat = (sel && !is_st(op) && !exp_e) ? 1 : 0;

        @(negedge clk);
        drive(sel, 1'b1, op, addr, wdata);
        set_rr(sel, hold == 0);
        waited = 0;
        while (!rdy(sel) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({nm, " req_ready"}, rdy(sel), 1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, op, addr, wdata);
        lat = 0;
        while (!vld(sel) && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " err"}, errf(sel), exp_e);
        check({nm, " rdata"}, rdat(sel), exp_d);
        if (has_want) check({nm, " rdata_want"}, rdat(sel), want);
        check({nm, " busy"}, rdy(sel), 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({nm, " hold_valid"}, vld(sel), 1);
            check({nm, " hold_rdata"}, rdat(sel), exp_d);
            check({nm, " hold_busy"}, rdy(sel), 0);
        end
        set_rr(sel, 1'b1);
        @(posedge clk);
        #1;
        check({nm, " released"}, vld(sel), 0);
        check({nm, " idle_ready"}, rdy(sel), 1);
    endtask

    initial begin
        bit          s;
        logic [3:0]  op;
        logic [31:0] off;
        logic [63:0] wd;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 64'h0);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 64'h0);
        set_rr(1'b0, 1'b1);
        set_rr(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d req_ready", i), rdy(i[0]), 0);
            check($sformatf("rst%0d rsp_valid", i), vld(i[0]), 0);
            check($sformatf("rst%0d rsp_rdata", i), rdat(i[0]), 0);
            check($sformatf("rst%0d rsp_err", i), errf(i[0]), 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) do_req(1'b0, DMOP_SW, A_BASE + 32'(4 * i), 64'h0, 0, 1'b0, 64'h0);
        for (int i = 0; i < 32; i++) do_req(1'b1, DMOP_SD, B_BASE + 32'(8 * i), 64'h0, 0, 1'b0, 64'h0);

        // 32-bit, single-cycle instance
        do_req(1'b0, DMOP_SW,   32'h10, 64'h11223344, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LW,   32'h10, 64'h0, 0, 1'b1, 64'h11223344);
        do_req(1'b0, DMOP_SB,   32'h13, 64'hAB, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LB,   32'h13, 64'h0, 0, 1'b1, 64'h000000AB);
        do_req(1'b0, DMOP_LW,   32'h10, 64'h0, 0, 1'b1, 64'h112233AB);
        do_req(1'b0, DMOP_LH,   32'h12, 64'h0, 0, 1'b1, 64'h000033AB);
        do_req(1'b0, DMOP_SH,   32'h14, 64'h80FF, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LHA,  32'h14, 64'h0, 0, 1'b1, 64'hFFFF80FF);
        do_req(1'b0, DMOP_SWBR, 32'h20, 64'h11223344, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LW,   32'h20, 64'h0, 0, 1'b1, 64'h44332211);
        do_req(1'b0, DMOP_LWBR, 32'h20, 64'h0, 0, 1'b1, 64'h11223344);
        do_req(1'b0, DMOP_LHBR, 32'h22, 64'h0, 0, 1'b1, 64'h00001122);
        do_req(1'b0, DMOP_LW,   32'h11, 64'h0, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_SH,   32'h13, 64'hFFFF, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LW,   32'h10, 64'h0, 0, 1'b1, 64'h112233AB);
        do_req(1'b0, DMOP_LW,   32'h100, 64'h0, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LWA,  32'h10, 64'h0, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_SD,   32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'h0);
        do_req(1'b0, DMOP_LW,   32'h10, 64'h0, 2, 1'b1, 64'h112233AB);

        // 64-bit, two-cycle instance
        do_req(1'b1, DMOP_SD,   B_BASE + 32'h8, 64'h0102030405060708, 0, 1'b1, 64'h0);
        do_req(1'b1, DMOP_LD,   B_BASE + 32'h8, 64'h0, 3, 1'b1, 64'h0102030405060708);
        do_req(1'b1, DMOP_SW,   B_BASE + 32'hC, 64'h85060708, 0, 1'b1, 64'h0);
        do_req(1'b1, DMOP_LWA,  B_BASE + 32'hC, 64'h0, 0, 1'b1, 64'hFFFFFFFF85060708);
        do_req(1'b1, DMOP_LD,   B_BASE + 32'h8, 64'h0, 0, 1'b1, 64'h0102030485060708);
        do_req(1'b1, DMOP_LD,   B_BASE + 32'hC, 64'h0, 0, 1'b1, 64'h0);
        do_req(1'b1, DMOP_LW,   B_BASE - 32'h8, 64'h0, 0, 1'b1, 64'h0);

        // Reset during RD_WAIT: response never appears, unit is ready after release.
        @(negedge clk);
        drive(1'b1, 1'b1, DMOP_LD, B_BASE + 32'h8, 64'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, DMOP_LD, B_BASE + 32'h8, 64'h0);
        #1 rst_n = 1'b0;
        #1;
        check("rstwait rsp_valid", b_rsp_valid, 0);
        check("rstwait req_ready", b_req_ready, 0);
        @(posedge clk);
        #1;
        check("rstwait held_valid", b_rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstwait idle_ready", b_req_ready, 1);
        check("rstwait idle_valid", b_rsp_valid, 0);

        // Reset while a response is held: rsp_valid drops at once.
        @(negedge clk);
        a_rsp_ready = 1'b0;
        drive(1'b0, 1'b1, DMOP_LW, 32'h10, 64'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, DMOP_LW, 32'h10, 64'h0);
        check("rstresp valid_before", a_rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstresp rsp_valid", a_rsp_valid, 0);
        check("rstresp rsp_rdata", {32'h0, a_rsp_rdata}, 0);
        a_rsp_ready = 1'b1;

        // Store presented as reset asserts just before the edge must not write.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, DMOP_SB, 32'h10, 64'hEE);
        #4 rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, DMOP_SB, 32'h10, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, DMOP_LB, 32'h10, 64'h0, 0, 1'b1, 64'h11);

        for (int i = 0; i < 300; i++) begin
            s  = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 13));
            case ($urandom_range(0, 15))
                0, 1:    off = 32'($urandom_range(240, 300));
                2:       off = 32'hFFFF_FFF8;
                3, 4, 5: off = 32'($urandom_range(0, 63));
                default: off = 32'($urandom_range(0, 63)) & ~32'h7;
            endcase
            wd = {$urandom, $urandom};
            do_req(s, op, off + (s ? B_BASE : A_BASE), wd, $urandom_range(0, 2), 1'b0, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Parametrised data-memory load/store unit. Replaces the separate DM, DMIn_BE and DMOut_ME blocks with one block behind a valid/ready request/response interface.
- Contains the data array, byte-lane steering, byte-reverse, sign/zero extension, alignment and range checking, and configurable read latency.
- Sits in the MEM stage. The pipeline stalls on !req_ready or on a missing rsp_valid.

Parameters:
- DATA_W, 32: memory word width; 32 or 64 only.
- DEPTH_LOG2, 10: log2 of the number of words.
- ADDR_W, 32: byte-address width.
- BASE_ADDR, 0: byte address of word 0.
- RD_LAT, 1: array read latency in cycles; 1 or 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  4  operation code (see package)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset values: state=IDLE, req_ready=0 while rst_n=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The array is not reset. Simulation initialises it to 0.
- Endianness: big-endian. Byte offset k within a word occupies bits [DATA_W-1-8k -: 8].
- Ops:
  - Loads: LB, LH, LHA, LHBR, LW, LWA, LWBR, plus LD when DATA_W=64.
  - Stores: SB, SH, SHBR, SW, SWBR, plus SD when DATA_W=64.
  - LHA and LWA sign-extend; all other loads zero-extend.
  - The *BR ops byte-reverse within the access size.
  - LWA and LD/SD are illegal when DATA_W=32 and report rsp_err=1.
- Address:
  - off = req_addr - BASE_ADDR.
  - Word index = off[DEPTH_LOG2+log2(DATA_W/8)-1 : log2(DATA_W/8)].
  - Out of range: any off bit above the index field is set.
- Misalignment:
  - Half-word access with off[0]=1.
  - Word access with off[1:0]!=0.
  - Double-word access with off[2:0]!=0.
- Errored access: no write, rsp_err=1, rsp_rdata=0.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: req_ready=1. An accept is req_valid and req_ready at edge T.
    - Store, or any errored access: the write occurs at T if legal. Go to RESP; rsp_valid=1 from T+1.
    - Legal load with RD_LAT=1: go to RESP; rsp_valid=1 from T+1.
    - Legal load with RD_LAT=2: go to RD_WAIT, latch op and offset, then RESP. rsp_valid=1 from T+2.
  - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
    - req_ready=0 in RD_WAIT and RESP, so there is no overlap.
    - Maximum throughput is one access per 2 cycles when rsp_ready is tied high.
- Store byte enables:
  - Written per lane: only enabled bytes change.
  - Enables: SB sets 1 lane; SH/SHBR set 2 lanes at off; SW/SWBR set 4 lanes at off; SD sets all lanes.
- Load after store to the same address, in the next accepted request: returns the new data. The write commits at edge T, before any later read.
- Reset asserted mid-operation:
  - FSM returns to IDLE and rsp_valid drops at once.
  - The write of a store accepted at the same edge as reset assertion is not performed.
- Load data is captured from the array into an internal register. rsp_rdata comes from that register, never straight from the array.

Decomposition:
- Package dm_lsu_pkg:
  - op encodings: DMOP_LB, DMOP_LH, DMOP_LHA, DMOP_LHBR, DMOP_LW, DMOP_LWA, DMOP_LWBR, DMOP_LD, DMOP_SB, DMOP_SH, DMOP_SHBR, DMOP_SW, DMOP_SWBR, DMOP_SD;
  - DMOP_WIDTH=4;
  - FSM state constants;
  - helper functions: op_is_store, op_size_log2.
- One combinational sub-module, dm_lane_steer. It takes op, offset and data, and produces:
  - store lane data and byte-enable vector;
  - load extract, byte-reverse and extend;
  - the misalign flag.

Test Plan:
- DATA_W=32, RD_LAT=1: SW 0x11223344 @0x10, then LW @0x10 → rsp_rdata=0x11223344 one cycle after accept, rsp_err=0.
- SB 0xAB @0x13, then LB @0x13 → 0x000000AB. LW @0x10 → 0x112233AB. LH @0x12 with 0x33AB stored → 0x000033AB. LHA of 0x80FF → 0xFFFF80FF.
- SWBR 0x11223344 @0x20, then LW → 0x44332211. LWBR @0x20 → 0x11223344. LHBR @0x22 of 0x2211 → 0x00001122.
- Misaligned LW @0x11 and SH @0x13 → rsp_err=1, rsp_rdata=0, memory unchanged. Out-of-range LW @(BASE+4·2^DEPTH_LOG2) → rsp_err=1.
- RD_LAT=2 with rsp_ready held low for 3 cycles → rsp_valid from T+2, data stable, req_ready=0 throughout. Drop rst_n during RD_WAIT → rsp_valid=0 immediately, IDLE after release.
- DATA_W=64: SD 0x0102030405060708 @0x8, LWA @0xC of 0x85060708 → 0xFFFFFFFF85060708. LD @0x8 → 0x0102030405060708.
